// File: rtl/rpn_pkg.sv
// -----------------------------------------------------------------------------
// rpn_pkg
// Shared types for the RPN engine: command opcodes, sequencer states and the
// sticky error codes reported on ERR.
// -----------------------------------------------------------------------------
package rpn_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_PUSH = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_XOR  = 3'b101,
    OP_DUP  = 3'b110,
    OP_DROP = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP_B,
    S_POP_A,
    S_RESTORE,
    S_PEEK,
    S_EXEC,
    S_PUSH_R
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

endpackage

// File: rtl/rpn_alu.sv
// -----------------------------------------------------------------------------
// rpn_alu
// Combinational ALU for the RPN engine. Computes A op B, wrapping modulo
// 2^WIDTH. Non-ALU opcodes produce zero.
//
// Build option: RPN_CARRY_EN
//   defined   : ADD reports carry-out, SUB reports borrow (A < B),
//               AND/XOR report 0.
//   undefined : datapath is WIDTH bits only and o_carry is constant 0.
//
// Ports
//   i_a, i_b  : operands (A = second pop, B = top of stack)
//   i_op      : opcode
//   o_r       : result
//   o_carry   : carry / borrow flag
// -----------------------------------------------------------------------------
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  op_e              i_op,
  output logic [WIDTH-1:0] o_r,
  output logic             o_carry
);

`ifdef RPN_CARRY_EN
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  // The extra MSB of the widened difference is the borrow out (A < B).
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    o_r     = '0;
    o_carry = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_r     = w_sum[WIDTH-1:0];
        o_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        o_r     = w_diff[WIDTH-1:0];
        o_carry = w_diff[WIDTH];
      end
      OP_AND: o_r = i_a & i_b;
      OP_XOR: o_r = i_a ^ i_b;
      default: ;
    endcase
  end
`else
  always_comb begin
    o_r = '0;
    case (i_op)
      OP_ADD:  o_r = i_a + i_b;
      OP_SUB:  o_r = i_a - i_b;
      OP_AND:  o_r = i_a & i_b;
      OP_XOR:  o_r = i_a ^ i_b;
      default: ;
    endcase
  end

  assign o_carry = 1'b0;
`endif

endmodule

// File: rtl/rpn_engine.sv
// -----------------------------------------------------------------------------
// rpn_engine
// Command-driven initiator for the shared stack block. Accepts PUSH and
// arithmetic opcodes on a valid/ready port, sequences pop/push strobes on the
// stack, and pushes results back, making the stack a small RPN calculator.
//
// Build option: RPN_CARRY_EN (carry/borrow reporting, see rpn_alu).
//
// Ports
//   CLK, RST_N            : clock, asynchronous active-low reset
//   CMD_VALID/CMD_READY   : command handshake (ready only in IDLE)
//   CMD_OP, CMD_DATA      : opcode and PUSH literal
//   RESULT, RESULT_VALID  : last ALU/DUP value and its push pulse
//   ERR                   : sticky error (00 none, 01 underflow, 10 overflow)
//   CARRY                 : carry/borrow of the last ADD/SUB/AND/XOR
//   STK_PUSH, STK_POP     : stack strobes
//   STK_DIN               : stack push data
//   STK_DOUT              : stack top (combinational from the stack)
//   STK_FULL, STK_EMPTY   : stack status
// -----------------------------------------------------------------------------
module rpn_engine
  import rpn_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [2:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_DATA,
  output logic [WIDTH-1:0] RESULT,
  output logic             RESULT_VALID,
  output logic [1:0]       ERR,
  output logic             CARRY,
  output logic             STK_PUSH,
  output logic             STK_POP,
  output logic [WIDTH-1:0] STK_DIN,
  input  logic [WIDTH-1:0] STK_DOUT,
  input  logic             STK_FULL,
  input  logic             STK_EMPTY
);

  state_e           r_state;
  state_e           w_next;
  op_e              r_op;
  op_e              w_cmd_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_err;
  logic             r_carry;
  logic [WIDTH-1:0] w_alu_r;
  logic             w_alu_carry;

  assign w_cmd_op = op_e'(CMD_OP);

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_op    (r_op),
    .o_r     (w_alu_r),
    .o_carry (w_alu_carry)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and strobe decode. Outputs depend only on state, registers and
  // stack status, never on CMD_*.
  always_comb begin
    w_next       = r_state;
    CMD_READY    = 1'b0;
    STK_PUSH     = 1'b0;
    STK_POP      = 1'b0;
    STK_DIN      = '0;
    RESULT_VALID = 1'b0;
    case (r_state)
      S_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          case (w_cmd_op)
            OP_PUSH:                               w_next = S_PUSH_R;
            OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_DROP: w_next = S_POP_B;
            OP_DUP:                                w_next = S_PEEK;
            default:                               w_next = S_IDLE;
          endcase
        end
      end
      S_POP_B: begin
        if (STK_EMPTY) begin
          w_next = S_IDLE;
        end else begin
          STK_POP = 1'b1;
          w_next  = (r_op == OP_DROP) ? S_IDLE : S_POP_A;
        end
      end
      S_POP_A: begin
        if (STK_EMPTY) begin
          w_next = S_RESTORE;
        end else begin
          STK_POP = 1'b1;
          w_next  = S_EXEC;
        end
      end
      // B was just popped, so the stack cannot be full here.
      S_RESTORE: begin
        STK_PUSH = 1'b1;
        STK_DIN  = r_b;
        w_next   = S_IDLE;
      end
      S_PEEK:  w_next = STK_EMPTY ? S_IDLE : S_PUSH_R;
      S_EXEC:  w_next = S_PUSH_R;
      S_PUSH_R: begin
        if (!STK_FULL) begin
          STK_PUSH     = 1'b1;
          STK_DIN      = r_r;
          RESULT_VALID = (r_op != OP_PUSH);
        end
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath. r_r holds the PUSH literal, the peeked DUP value or the ALU
  // result; whichever it is, PUSH_R writes it to the stack.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_op     <= OP_NOP;
      r_a      <= '0;
      r_b      <= '0;
      r_r      <= '0;
      r_result <= '0;
      r_err    <= ERR_NONE;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (CMD_VALID) begin
            r_op <= w_cmd_op;
            r_r  <= CMD_DATA;
            if (w_cmd_op == OP_NOP) r_err <= ERR_NONE;
          end
        end
        S_POP_B: begin
          if (STK_EMPTY) r_err <= ERR_UNDER;
          else           r_b   <= STK_DOUT;
        end
        S_POP_A: begin
          if (!STK_EMPTY) r_a <= STK_DOUT;
        end
        S_RESTORE: r_err <= ERR_UNDER;
        S_PEEK: begin
          if (STK_EMPTY) begin
            r_err <= ERR_UNDER;
          end else begin
            r_r      <= STK_DOUT;
            r_result <= STK_DOUT;
          end
        end
        S_EXEC: begin
          r_r      <= w_alu_r;
          r_result <= w_alu_r;
          r_carry  <= w_alu_carry;
        end
        S_PUSH_R: begin
          if (STK_FULL) r_err <= ERR_OVER;
        end
        default: ;
      endcase
    end
  end

  assign RESULT = r_result;
  assign ERR    = r_err;
  assign CARRY  = r_carry;

endmodule

// File: tb/tb_rpn_engine.sv
// -----------------------------------------------------------------------------
// tb_rpn_engine
// Directed bench for rpn_engine with a behavioural DEPTH-8 stack. Expected
// ALU/DUP results are queued when a command is issued; a monitor pops and
// compares them whenever RESULT_VALID is seen.
// -----------------------------------------------------------------------------
module tb_rpn_engine;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  localparam logic [2:0] C_NOP  = 3'b000;
  localparam logic [2:0] C_PUSH = 3'b001;
  localparam logic [2:0] C_ADD  = 3'b010;
  localparam logic [2:0] C_SUB  = 3'b011;
  localparam logic [2:0] C_AND  = 3'b100;
  localparam logic [2:0] C_XOR  = 3'b101;
  localparam logic [2:0] C_DUP  = 3'b110;
  localparam logic [2:0] C_DROP = 3'b111;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             CMD_VALID = 1'b0;
  logic             CMD_READY;
  logic [2:0]       CMD_OP = 3'b000;
  logic [WIDTH-1:0] CMD_DATA = '0;
  logic [WIDTH-1:0] RESULT;
  logic             RESULT_VALID;
  logic [1:0]       ERR;
  logic             CARRY;
  logic             STK_PUSH;
  logic             STK_POP;
  logic [WIDTH-1:0] STK_DIN;
  logic [WIDTH-1:0] STK_DOUT;
  logic             STK_FULL;
  logic             STK_EMPTY;

  int n_checks = 0;
  int n_errors = 0;
  int n_viol   = 0;

  typedef struct {
    logic [WIDTH-1:0] r;
    logic             c;
  } exp_t;

  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  rpn_engine #(.WIDTH(WIDTH)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .CMD_VALID    (CMD_VALID),
    .CMD_READY    (CMD_READY),
    .CMD_OP       (CMD_OP),
    .CMD_DATA     (CMD_DATA),
    .RESULT       (RESULT),
    .RESULT_VALID (RESULT_VALID),
    .ERR          (ERR),
    .CARRY        (CARRY),
    .STK_PUSH     (STK_PUSH),
    .STK_POP      (STK_POP),
    .STK_DIN      (STK_DIN),
    .STK_DOUT     (STK_DOUT),
    .STK_FULL     (STK_FULL),
    .STK_EMPTY    (STK_EMPTY)
  );

  // Behavioural stack: strobes take effect at the edge ending the strobe cycle.
  logic [WIDTH-1:0] stk_mem [DEPTH];
  int               stk_cnt;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stk_cnt <= 0;
    end else if (STK_PUSH && stk_cnt < DEPTH) begin
      stk_mem[stk_cnt] <= STK_DIN;
      stk_cnt          <= stk_cnt + 1;
    end else if (STK_POP && stk_cnt > 0) begin
      stk_cnt <= stk_cnt - 1;
    end
  end

  assign STK_FULL  = (stk_cnt == DEPTH);
  assign STK_EMPTY = (stk_cnt == 0);
  assign STK_DOUT  = (stk_cnt > 0) ? stk_mem[stk_cnt-1] : '0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic exp_c(input logic c);
`ifdef RPN_CARRY_EN
    return c;
`else
    return 1'b0 & c;
`endif
  endfunction

  // Strobe invariants, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RST_N) begin
      if ((STK_PUSH && STK_FULL) || (STK_POP && STK_EMPTY) || (STK_PUSH && STK_POP))
        n_viol++;
    end
  end

  // Scoreboard monitor.
  always @(negedge CLK) begin
    if (RST_N && RESULT_VALID) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", int'(RESULT), int'(e.r));
        check("carry", int'(CARRY), int'(e.c));
      end
    end
  end

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Issue one command and measure cycles from the accept edge until ready.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] data,
                      input int exp_lat);
    int cyc;
    cyc = 0;
    @(negedge CLK);
    while (!CMD_READY && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
    if (!CMD_READY) check("ready_timeout_pre", 0, 1);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_DATA  = data;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    cyc = 1;
    while (!CMD_READY && cyc < 20) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    check($sformatf("latency_op%0d", op), cyc, exp_lat);
  endtask

  task automatic expect_res(input logic [WIDTH-1:0] r, input logic c);
    exp_t e;
    e.r = r;
    e.c = exp_c(c);
    exp_q.push_back(e);
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_ready", int'(CMD_READY), 1);
    check("rst_result", int'(RESULT), 0);
    check("rst_err", int'(ERR), 0);
    check("rst_carry", int'(CARRY), 0);
    check("rst_strobes", int'({RESULT_VALID, STK_PUSH, STK_POP}), 0);
    check("rst_din", int'(STK_DIN), 0);

    // 3 - 5 wraps to 14 with borrow.
    send(C_PUSH, 4'd3, 2);
    send(C_PUSH, 4'd5, 2);
    expect_res(4'd14, 1'b1);
    send(C_SUB, 4'd0, 5);
    check("sub_top", int'(STK_DOUT), 14);
    check("sub_depth", stk_cnt, 1);
    send(C_DROP, 4'd0, 2);
    check("drop_depth", stk_cnt, 0);

    // 9 + 8 wraps to 1 with carry.
    send(C_PUSH, 4'd9, 2);
    send(C_PUSH, 4'd8, 2);
    expect_res(4'd1, 1'b1);
    send(C_ADD, 4'd0, 5);
    check("add_top", int'(STK_DOUT), 1);
    check("add_depth", stk_cnt, 1);
    check("add_err", int'(ERR), 0);

    // Underflow on the second pop restores the stack.
    do_reset();
    send(C_PUSH, 4'd7, 2);
    send(C_ADD, 4'd0, 4);
    check("restore_err", int'(ERR), 1);
    check("restore_top", int'(STK_DOUT), 7);
    check("restore_depth", stk_cnt, 1);
    send(C_NOP, 4'd0, 1);
    check("nop_clear", int'(ERR), 0);
    send(C_DROP, 4'd0, 2);

    // Overflow on the ninth push.
    for (int i = 1; i <= 9; i++) send(C_PUSH, 4'(i), 2);
    check("ovf_err", int'(ERR), 2);
    check("ovf_top", int'(STK_DOUT), 8);
    check("ovf_depth", stk_cnt, 8);
    send(C_DUP, 4'd0, 3);
    check("dup_full_err", int'(ERR), 2);
    check("dup_full_depth", stk_cnt, 8);

    // Empty-stack DUP and DROP.
    do_reset();
    send(C_DUP, 4'd0, 2);
    check("dup_empty_err", int'(ERR), 1);
    check("dup_empty_depth", stk_cnt, 0);
    send(C_NOP, 4'd0, 1);
    check("nop_clear2", int'(ERR), 0);
    send(C_DROP, 4'd0, 2);
    check("drop_empty_err", int'(ERR), 1);
    check("drop_empty_depth", stk_cnt, 0);
    send(C_PUSH, 4'd6, 2);
    expect_res(4'd6, 1'b0);
    send(C_DUP, 4'd0, 3);
    check("dup_depth", stk_cnt, 2);
    check("dup_result", int'(RESULT), 6);

    // Logic ops and a non-borrowing SUB: [6,6] -> [6,6,12,10].
    send(C_PUSH, 4'd12, 2);
    send(C_PUSH, 4'd10, 2);
    expect_res(4'd8, 1'b0);
    send(C_AND, 4'd0, 5);
    expect_res(4'd14, 1'b0);
    send(C_XOR, 4'd0, 5);
    send(C_PUSH, 4'd2, 2);
    expect_res(4'd12, 1'b0);
    send(C_SUB, 4'd0, 5);
    check("logic_top", int'(STK_DOUT), 12);
    check("logic_depth", stk_cnt, 2);

    // Reset while an ADD is in EXEC.
    send(C_PUSH, 4'd5, 2);
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_OP    = C_ADD;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    check("abort_ready", int'(CMD_READY), 1);
    check("abort_result", int'(RESULT), 0);
    check("abort_err_carry", int'({ERR, CARRY}), 0);
    check("abort_strobes", int'({RESULT_VALID, STK_PUSH, STK_POP}), 0);
    check("abort_din", int'(STK_DIN), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("abort_ready_rel", int'(CMD_READY), 1);
    send(C_PUSH, 4'd4, 2);
    check("abort_push_top", int'(STK_DOUT), 4);
    check("abort_push_depth", stk_cnt, 1);

    repeat (2) @(posedge CLK);
    check("results_pending", exp_q.size(), 0);
    check("strobe_violations", n_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rpn_engine.md
# rpn_engine

Command-driven initiator for the shared `stack` block. It accepts push and arithmetic opcodes on a valid/ready command port, sequences PUSH/POP strobes onto the stack's port set, and pushes results back onto the stack. It sits between the top-level pin decode and `stack`, turning the stack into a tiny RPN calculator.

## Interface
Parameters:
- `WIDTH`, 4, data width; must equal the stack's data width.

Ports:
- `CLK` in 1: single clock domain, rising-edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `CMD_VALID` in 1: a command is offered.
- `CMD_READY` out 1: the engine accepts a command; high only in IDLE.
- `CMD_OP` in 3: opcode.
- `CMD_DATA` in WIDTH: literal; used only by PUSH.
- `RESULT` out WIDTH: last ALU or DUP value.
- `RESULT_VALID` out 1: one-cycle pulse when `RESULT` is pushed.
- `ERR` out 2: sticky error code; 00 none, 01 underflow, 10 overflow.
- `CARRY` out 1: carry or borrow flag (see Configuration).
- `STK_PUSH` out 1: push strobe to the stack.
- `STK_POP` out 1: pop strobe to the stack.
- `STK_DIN` out WIDTH: push data.
- `STK_DOUT` in WIDTH: top of stack, combinational, valid when `!STK_EMPTY`.
- `STK_FULL` in 1: stack full.
- `STK_EMPTY` in 1: stack empty.

## Operation
Stack contract:
- A push or pop takes effect on the `CLK` edge ending the strobe cycle.
- `STK_DOUT` reflects the new top on the following cycle.

Opcodes:
- 000 NOP: clears `ERR`.
- 001 PUSH.
- 010 ADD.
- 011 SUB.
- 100 AND.
- 101 XOR.
- 110 DUP.
- 111 DROP.

Binary operations use B = first pop (top) and A = second pop, and compute A op B. Arithmetic wraps modulo 2^WIDTH.

States and transitions (one cycle each unless noted):
- IDLE: `CMD_READY`=1. On `CMD_VALID`&&`CMD_READY`, latch op and data, then:
  - PUSH → PUSH_R.
  - Binary op or DROP → POP_B.
  - DUP → PEEK.
  - NOP: clear `ERR`, stay in IDLE.
- POP_B:
  - `STK_EMPTY`: set `ERR`=01 → IDLE.
  - Otherwise: B←`STK_DOUT`, `STK_POP`=1, then DROP → IDLE, other ops → POP_A.
- POP_A:
  - `STK_EMPTY` → RESTORE.
  - Otherwise: A←`STK_DOUT`, `STK_POP`=1 → EXEC.
- RESTORE: `STK_PUSH`=1, `STK_DIN`=B, `ERR`=01 → IDLE. The stack is left exactly as it was before the command.
- PEEK:
  - `STK_EMPTY`: `ERR`=01 → IDLE.
  - Otherwise: R←`STK_DOUT` → PUSH_R.
- EXEC: R←alu(A,B), `RESULT`←R, `CARRY` updated → PUSH_R.
- PUSH_R:
  - `STK_FULL`: `ERR`=10, no strobe, value dropped → IDLE.
  - Otherwise: `STK_PUSH`=1, `STK_DIN`=R (or the literal for PUSH). `RESULT_VALID`=1 for ALU and DUP only → IDLE.

Invariants:
- `STK_PUSH` and `STK_POP` are never high in the same cycle.
- No strobe is driven while `STK_FULL` (push) or `STK_EMPTY` (pop).
- `ERR` holds its value until a NOP is accepted. A new error overwrites the code. Commands still execute while `ERR`≠00.

## Timing
- All outputs are registered or decoded from state; there are no combinational paths from `CMD_*` to the outputs.
- Reset values:
  - State IDLE.
  - `CMD_READY`=1.
  - `RESULT`=0, `RESULT_VALID`=0, `ERR`=00, `CARRY`=0.
  - `STK_PUSH`=0, `STK_POP`=0, `STK_DIN`=0.
- Latency from accept edge back to `CMD_READY`=1:
  - PUSH: 2 cycles.
  - Binary op: 5 cycles.
  - DUP: 3 cycles.
  - DROP: 2 cycles.
  - NOP: 1 cycle.
- Reset asserted mid-command aborts immediately and drives every output to its reset value. `stack` shares `RST_N`.

## Configuration
`RPN_CARRY_EN`:
- Defined:
  - ADD sets `CARRY` to the carry-out of A+B.
  - SUB sets `CARRY`=1 when A<B (borrow).
  - AND and XOR clear `CARRY`.
- Undefined: `CARRY` is tied to 0 and the ALU is WIDTH bits only. The port is present in both builds.

## Structure
- `rpn_pkg` holds:
  - The opcode enum (`OP_NOP`…`OP_DROP`).
  - The state enum.
  - The error-code constants (`ERR_NONE`, `ERR_UNDER`, `ERR_OVER`).
- Sub-module `rpn_alu`: combinational; inputs A, B, op; outputs R and carry. Contains the `RPN_CARRY_EN` logic.
- The top level stays as-is and instantiates `rpn_engine` → `stack`.

## Test plan
All scenarios use WIDTH=4 and a stack of DEPTH 8.
- Push 3, push 5, SUB → pushes 14. `RESULT`=14, `RESULT_VALID` pulses once, `CARRY`=1 with `RPN_CARRY_EN`, `STK_DOUT`=14.
- Push 9, push 8, ADD → `RESULT`=1, `CARRY`=1 (0 without the macro). The stack holds one entry.
- Reset, push 7, ADD → `ERR`=01, RESTORE re-pushes 7, `STK_DOUT`=7, `STK_EMPTY`=0. Then NOP → `ERR`=00.
- 9 consecutive PUSH of 1..9 → `ERR`=10 on the 9th, top remains 8, `STK_PUSH` never high while `STK_FULL`. Then DUP → still `ERR`=10, no push.
- DUP and DROP on an empty stack → `ERR`=01 each, no strobes. Push 6, DUP → 2 entries, `RESULT`=6.
- Deassert `RST_N` during EXEC of an ADD → all outputs at reset values at once, `CMD_READY`=1 after release, and the next PUSH works.
